// File: rtl/dig_scan_ctrl.sv
// dig_scan_ctrl: register-mapped multiplexed 7-segment display scanner.
// Shows DATA as hex nibbles or as decimal digits (via a serial double-dabble
// converter into a BCD shadow), with per-digit decimal point, blink and
// leading-zero blanking. One digit is driven at a time, SCAN_DIV clocks each.
module dig_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           addr,
  input  logic                  we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] led_en,
  output logic [7:0]            led_seg0,
  output logic [7:0]            led_seg1
);

  localparam int SCW = $clog2(SCAN_DIV);
  localparam int BLW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic [31:0] data_reg;
  logic [2:0]  ctrl_reg;        // {LZ_BLANK, DEC_MODE, ENABLE}
  logic [7:0]  dp_mask_reg;
  logic [7:0]  blink_mask_reg;
  logic [1:0]  reg_sel;
  logic        wr_data;
  logic        wr_ctrl;
  logic        unused_addr;

  assign reg_sel     = addr[3:2];
  assign wr_data     = we && (reg_sel == 2'd0);
  assign wr_ctrl     = we && (reg_sel == 2'd1);
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  // Register writes: one register per cycle selected by addr[3:2]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg       <= '0;
      ctrl_reg       <= 3'b001;
      dp_mask_reg    <= '0;
      blink_mask_reg <= '0;
    end else if (we) begin
      case (reg_sel)
        2'd0: data_reg       <= wdata;
        2'd1: ctrl_reg       <= wdata[2:0];
        2'd2: dp_mask_reg    <= wdata[7:0];
        2'd3: blink_mask_reg <= wdata[7:0];
      endcase
    end
  end

  // Combinational readback, unused bits read as zero
  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata = data_reg;
      2'd1: rdata = {29'd0, ctrl_reg};
      2'd2: rdata = {24'd0, dp_mask_reg};
      2'd3: rdata = {24'd0, blink_mask_reg};
    endcase
  end

  // ---------------------------------------------------------------------
  // Double-dabble converter: 32 shifts, result latched into the shadow
  // only on the last shift so partial results are never displayed.
  // ---------------------------------------------------------------------
  logic [39:0] dd_bcd_reg;
  logic [31:0] dd_bin_reg;
  logic [5:0]  dd_cnt_reg;
  logic        busy_reg;
  logic [39:0] dd_adj;
  logic [39:0] dd_bcd_next;
  logic [31:0] dd_bin_next;
  logic        ovf_next;
  logic        conv_start;
  logic [31:0] conv_src;
  logic [31:0] shadow_bcd_reg;
  logic        shadow_ovf_reg;

  // A DATA write always (re)starts; enabling decimal mode starts from DATA
  assign conv_start = wr_data || (wr_ctrl && wdata[1] && !ctrl_reg[1]);
  assign conv_src   = wr_data ? wdata : data_reg;

  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_dd_adj
      assign dd_adj[4*gi +: 4] = (dd_bcd_reg[4*gi +: 4] >= 4'd5)
                               ? dd_bcd_reg[4*gi +: 4] + 4'd3
                               : dd_bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign dd_bcd_next = {dd_adj[38:0], dd_bin_reg[31]};
  assign dd_bin_next = {dd_bin_reg[30:0], 1'b0};
  // Any non-zero BCD digit beyond the displayable ones means overflow
  assign ovf_next    = |dd_bcd_next[39:4*NUM_DIGITS];

  // Converter sequencing and shadow load on the final shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dd_bcd_reg     <= '0;
      dd_bin_reg     <= '0;
      dd_cnt_reg     <= '0;
      busy_reg       <= 1'b0;
      shadow_bcd_reg <= '0;
      shadow_ovf_reg <= 1'b0;
    end else if (conv_start) begin
      dd_bcd_reg <= '0;
      dd_bin_reg <= conv_src;
      dd_cnt_reg <= 6'd32;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      dd_bcd_reg <= dd_bcd_next;
      dd_bin_reg <= dd_bin_next;
      dd_cnt_reg <= dd_cnt_reg - 6'd1;
      if (dd_cnt_reg == 6'd1) begin
        busy_reg       <= 1'b0;
        shadow_bcd_reg <= dd_bcd_next[31:0];
        shadow_ovf_reg <= ovf_next;
      end
    end
  end

  assign busy = busy_reg;

  // ---------------------------------------------------------------------
  // Scan and blink timing
  // ---------------------------------------------------------------------
  logic [SCW-1:0]        scan_cnt_reg;
  logic                  tick;
  logic [NUM_DIGITS-1:0] led_en_reg;
  logic [NUM_DIGITS-1:0] led_en_rot;
  logic [BLW-1:0]        blink_cnt_reg;
  logic                  blink_phase_reg;

  assign tick = (scan_cnt_reg == SCW'(SCAN_DIV - 1));

  generate
    if (NUM_DIGITS == 1) begin : g_rot_one
      assign led_en_rot = led_en_reg;
    end else begin : g_rot_many
      assign led_en_rot = {led_en_reg[NUM_DIGITS-2:0], led_en_reg[NUM_DIGITS-1]};
    end
  endgenerate

  // Slot counter and one-hot digit rotation on each tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_reg <= '0;
      led_en_reg   <= NUM_DIGITS'(1);
    end else if (tick) begin
      scan_cnt_reg <= '0;
      led_en_reg   <= led_en_rot;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
    end
  end

  // Blink counter advances once per full rotation (leaving the last digit)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (tick && led_en_reg[NUM_DIGITS-1]) begin
      if (blink_cnt_reg == BLW'(BLINK_DIV - 1)) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  assign led_en = led_en_reg;

  // ---------------------------------------------------------------------
  // Per-digit segment generation and output mux
  // ---------------------------------------------------------------------
  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 8'hFC;
      4'h1: glyph = 8'h60;
      4'h2: glyph = 8'hDA;
      4'h3: glyph = 8'hF2;
      4'h4: glyph = 8'h66;
      4'h5: glyph = 8'hB6;
      4'h6: glyph = 8'hBE;
      4'h7: glyph = 8'hE0;
      4'h8: glyph = 8'hFE;
      4'h9: glyph = 8'hF6;
      4'hA: glyph = 8'hEE;
      4'hB: glyph = 8'h3E;
      4'hC: glyph = 8'h9C;
      4'hD: glyph = 8'h7A;
      4'hE: glyph = 8'h9E;
      4'hF: glyph = 8'h8E;
    endcase
  endfunction

  logic                  dec_mode;
  logic                  show_ovf;
  logic [3:0]            digit_val [NUM_DIGITS];
  logic [7:0]            digit_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_hit;
  logic [NUM_DIGITS:0]   zero_from;
  logic [7:0]            seg_mux;

  assign dec_mode = ctrl_reg[1];
  assign show_ovf = dec_mode && shadow_ovf_reg;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [7:0] base;
      logic       blank;

      assign digit_val[gi] = dec_mode ? shadow_bcd_reg[4*gi +: 4] : data_reg[4*gi +: 4];

      if (gi == 0) begin : g_lz_first
        assign lz_hit[gi] = 1'b0;
      end else begin : g_lz_rest
        assign lz_hit[gi] = ctrl_reg[2] && zero_from[gi] && !show_ovf;
      end

      assign base  = show_ovf ? 8'h02 : glyph(digit_val[gi]);
      assign blank = !ctrl_reg[0] || lz_hit[gi] || (blink_mask_reg[gi] && blink_phase_reg);
      assign digit_seg[gi] = blank ? 8'h00 : (base | {7'd0, dp_mask_reg[gi]});
    end
  endgenerate

  // zero_from[k]: digit k and every digit above it are zero
  always_comb begin
    zero_from             = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (digit_val[k] == 4'd0);
    end
  end

  // Select the segments of the currently enabled digit
  always_comb begin
    seg_mux = 8'h00;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (led_en_reg[k]) seg_mux = seg_mux | digit_seg[k];
    end
  end

  assign led_seg0 = seg_mux;
  assign led_seg1 = seg_mux;

endmodule

// File: doc/dig_scan_ctrl.md
DIG_SCAN_CTRL -- requirements
Module: dig_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, range 1..8, number of scanned digits.
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot (>=2).
REQ-003 SHALL have parameter BLINK_DIV, default 256, full scan rotations per blink half-period (>=1).
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 addr  input  32  register address; only addr[3:2] decoded.
REQ-007 we  input  1  write strobe, one write per asserted cycle.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  combinational readback of register selected by addr[3:2].
REQ-010 busy  output  1  high while decimal conversion is in progress.
REQ-011 led_en  output  NUM_DIGITS  one-hot digit enable, active-high.
REQ-012 led_seg0  output  8  segments {a,b,c,d,e,f,g,dp}, bit7=a, active-high.
REQ-013 led_seg1  output  8  identical copy of led_seg0.

Function
REQ-014 Registers: 0=DATA[31:0]; 1=CTRL {bit0 ENABLE, bit1 DEC_MODE, bit2 LZ_BLANK}; 2=DP_MASK[7:0]; 3=BLINK_MASK[7:0]; unused bits read 0.
REQ-015 Writes update the selected register on the clk edge with we=1; readback reflects the new value the following cycle.
REQ-016 Scan counter counts 0..SCAN_DIV-1 and wraps; tick = counter at SCAN_DIV-1.
REQ-017 On tick, led_en rotates left by one (digit k -> k+1, NUM_DIGITS-1 -> 0); no change otherwise.
REQ-018 Blink counter increments on each tick where led_en[NUM_DIGITS-1]=1; on reaching BLINK_DIV-1 it wraps and toggles blink_phase.
REQ-019 Digit value source: hex mode = DATA nibble k; decimal mode = BCD shadow digit k.
REQ-020 Glyphs: 0=FC,1=60,2=DA,3=F2,4=66,5=B6,6=BE,7=E0,8=FE,9=F6,A=EE,b=3E,C=9C,d=7A,E=9E,F=8E (hex, dp bit 0).
REQ-021 dp bit of active digit k = DP_MASK[k], OR'd onto glyph.
REQ-022 Blank (led_seg0=00, dp included) when: ENABLE=0; or BLINK_MASK[k]=1 and blink_phase=1; or LZ_BLANK=1 and k>0 and all digits k..NUM_DIGITS-1 are zero.
REQ-023 Digit 0 SHALL never be leading-zero blanked.
REQ-024 Decimal conversion (double-dabble) starts on DATA write or CTRL write setting DEC_MODE 0->1; 32 cycles, one shift per clk; busy high from the cycle after the write through the final shift.
REQ-025 At completion the BCD result loads the shadow in one cycle and busy falls in that same cycle.
REQ-026 Write to DATA while busy restarts conversion from the new value; completion count restarts at 32.
REQ-027 During conversion the display shows the previous shadow; no partial results visible.
REQ-028 If converted value exceeds 10^NUM_DIGITS-1, shadow holds overflow: all digits show 02 (segment g), dp and blink still applied, LZ blanking suppressed.
REQ-029 Only digits 0..NUM_DIGITS-1 of DATA, DP_MASK, BLINK_MASK are used; upper bits stored and read back.
REQ-030 Scan, blink and conversion run independently; simultaneous tick and register write both take effect in that cycle.

Reset
REQ-031 rst SHALL asynchronously clear DATA, DP_MASK, BLINK_MASK, BCD shadow, scan and blink counters, blink_phase, busy to 0.
REQ-032 Reset value of CTRL SHALL be 0x1 (enabled, hex, no LZ blank).
REQ-033 Reset value of led_en SHALL be one-hot digit 0; led_seg0/led_seg1 then show FC.
REQ-034 rst mid-conversion SHALL abort it; no shadow update after release.

Verification
REQ-035 Reset, DATA=0x1234ABCD, hex -> over 8 slots led_seg0 = 7A,9C,3E,EE,66,F2,DA,60 for digits 0..7, each slot SCAN_DIV cycles.
REQ-036 CTRL=0x3, DATA=12345 -> busy high 32 cycles, then digits 0..4 = B6,66,F2,DA,60, digits 5..7 = FC.
REQ-037 CTRL=0x7, DATA=7 -> digit0=E0, digits 1..7 = 00; DATA=0 -> digit0=FC only.
REQ-038 CTRL=0x3, DATA=100000000 (NUM_DIGITS=8) -> all digits 02 after busy falls.
REQ-039 BLINK_MASK=0x01, DP_MASK=0x02, BLINK_DIV=2 -> digit0 alternates glyph/00 every 2 rotations; digit1 bit0=1 always.
REQ-040 Write DATA=5 then DATA=9 at cycle 10 of conversion, rst mid-conversion in a second run -> first run shows F6 after 32 cycles from second write; reset run leaves shadow 0 and busy 0.
